uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

8N1 UART transmitter with a 4-entry byte FIFO, the transmit-side counterpart of the CPU's UART receive path. Sits between the peripheral bus write logic and the board `UART_TX` pin: the CPU pushes bytes whenever `wr_ready` is high, and the block serialises them LSB-first at a fixed baud divisor. Back-to-back queued bytes are sent with no idle gap between frames.

## Interface
Parameters:
- `BAUD_DIV`, default 10416: sysclk cycles per UART bit; 10416 at the board clock gives the 20833 ns bit period; legal range 2..65535.
- `FIFO_DEPTH`, fixed at 4: not overridable; the pointers are 2 bits wide.

Ports:
- `sysclk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset. Sampled on `sysclk` rising edge; low clears all state.
- `wr_data`  in  8  byte to enqueue.
- `wr_en`  in  1  enqueue request; takes effect on the edge where `wr_en && wr_ready`.
- `wr_ready`  out  1  FIFO not full; combinational from the registered count.
- `fifo_count`  out  3  number of queued bytes, 0..4; excludes the byte currently being shifted.
- `tx_busy`  out  1  high whenever the FSM is not in IDLE.
- `UART_TX`  out  1  serial line, registered, idle high.

## Operation
- FIFO: 4x8 storage, 2-bit `wr_ptr`/`rd_ptr`, 3-bit count; wrap 3->0.
  - Write while full is dropped silently; no state change.
  - Write and pop on the same edge leaves the count unchanged and is legal at every count, including full (pop frees the slot first) and empty-with-pending-write (not possible: pop requires count>0 before the edge).
- FSM states:
  - IDLE: `UART_TX`=1. If count>0, pop the head into `shift_reg`, drive `UART_TX`=0, load baud counter, go to START.
  - START: hold 0 for `BAUD_DIV` cycles, then drive `shift_reg[0]`, bit_idx=0, go to DATA.
  - DATA: each bit held `BAUD_DIV` cycles. At bit end, if bit_idx<7, shift right, increment, drive the next bit. If bit_idx==7, drive 1 and go to STOP.
  - STOP: hold 1 for `BAUD_DIV` cycles. At stop end, if count>0, pop and drive 0 directly (START, no idle cycle); otherwise go to IDLE.
- Baud counter: 16-bit down-counter loaded with `BAUD_DIV-1`. Bit end is when it reaches 0 with reload on the same edge. No drift: every bit is exactly `BAUD_DIV` cycles.
- Bit order: LSB first. Frame = 1 start + 8 data + 1 stop = `10*BAUD_DIV` cycles.
- Reset mid-frame aborts the frame. `UART_TX`=1 on the reset edge; FIFO contents are discarded (pointers and count zeroed, storage left undefined).

## Timing
- Reset values: `UART_TX`=1, `tx_busy`=0, `fifo_count`=0, `wr_ready`=1, FSM=IDLE.
- Latency from an idle, empty block:
  - Write accepted on edge N, so count=1 after N.
  - Pop on edge N+1, so `UART_TX` falls and `tx_busy` rises after N+1.
  - Start bit spans edges N+1..N+1+`BAUD_DIV`.
- `UART_TX` is 1 through the last stop-bit cycle; a chained frame's start bit begins on the very next cycle.
- `wr_ready` deasserts in the cycle after the edge that makes count=4. It reasserts the cycle after the pop edge.
- `tx_busy` falls on the edge where STOP ends with an empty FIFO.

## Test plan
Run with `BAUD_DIV`=16 unless noted; the bench samples `UART_TX` at mid-bit.
- Single byte: write 0x55 after reset.
  - `UART_TX` falls 2 cycles after the write cycle.
  - Bit sequence 0,1,0,1,0,1,0,1,0,1, each exactly 16 cycles.
  - `tx_busy` is high for 160 cycles, then IDLE.
- Burst/full: `wr_en` held on 6 consecutive cycles with 0x01..0x06.
  - 0x01..0x05 accepted; `wr_ready`=0 on the 6th cycle, so 0x06 is dropped.
  - Five contiguous frames over 800 cycles, no idle gap; decoded 0x01..0x05.
- Simultaneous write/pop: with count=4, issue a write on the stop-end edge.
  - Write accepted; count stays 4.
  - Next frame carries the oldest byte; the new byte is sent last.
- Reset mid-frame: assert `reset`=0 for 1 cycle during the 3rd data bit of 0xA3 with 2 bytes queued.
  - `UART_TX`=1 next cycle; `fifo_count`=0; `tx_busy`=0.
  - No further frames follow.
- Divisor edge: `BAUD_DIV`=2, write 0xFF.
  - Start bit 2 cycles low, then 18 cycles high.
  - Total frame 20 cycles.
- Full rate: `BAUD_DIV`=10416, write 0x00.
  - Start plus 8 data bits low for 93744 cycles, then high.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a 4-entry byte FIFO; frames are sent LSB-first
// back to back, with no idle cycle between queued bytes.
module uart_tx_fifo #(
  parameter int unsigned BAUD_DIV = 10416
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  output logic       wr_ready,
  output logic [2:0] fifo_count,
  output logic       tx_busy,
  output logic       UART_TX
);

  // state | meaning
  // IDLE  | line high, waiting for a queued byte
  // START | start bit (low) for BAUD_DIV cycles
  // DATA  | eight data bits, LSB first
  // STOP  | stop bit (high); chains straight into START if a byte is queued
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam int unsigned FIFO_DEPTH  = 4;
  localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        push, pop, bit_end;

  assign wr_ready   = (count_q != 3'(FIFO_DEPTH));
  // A pop on the same edge frees the head slot, so a write is taken even when full.
  assign push       = wr_en && (wr_ready || pop);
  assign bit_end    = (baud_q == 16'd0);
  assign fifo_count = count_q;
  assign tx_busy    = (state_q != S_IDLE);
  assign UART_TX    = tx_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (count_q != 3'd0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
          baud_d  = BAUD_RELOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d    = BAUD_RELOAD;
          tx_d      = shift_q[0];
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = BAUD_RELOAD;
          if (bit_idx_q != 3'd7) begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end else begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_d = BAUD_RELOAD;
          if (count_q != 3'd0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
      count_q   <= 3'd0;
      state_q   <= S_IDLE;
      baud_q    <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge sysclk) begin
    if (reset && push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: three instances (divisors 16, 2, 10416)
// share one clock; instance A is logged every cycle and frames are checked from the log.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A, BAUD_DIV=16
  logic       rstn_a = 1'b0, we_a = 1'b0;
  logic [7:0] wd_a = 8'h00;
  logic       rdy_a, busy_a, tx_a;
  logic [2:0] cnt_a;
  // instance B, BAUD_DIV=2
  logic       rstn_b = 1'b0, we_b = 1'b0;
  logic [7:0] wd_b = 8'h00;
  logic       rdy_b, busy_b, tx_b;
  logic [2:0] cnt_b;
  // instance C, BAUD_DIV=10416
  logic       rstn_c = 1'b0, we_c = 1'b0;
  logic [7:0] wd_c = 8'h00;
  logic       rdy_c, busy_c, tx_c;
  logic [2:0] cnt_c;

  uart_tx_fifo #(.BAUD_DIV(16)) dut_a (
    .sysclk(clk), .reset(rstn_a), .wr_data(wd_a), .wr_en(we_a),
    .wr_ready(rdy_a), .fifo_count(cnt_a), .tx_busy(busy_a), .UART_TX(tx_a));
  uart_tx_fifo #(.BAUD_DIV(2)) dut_b (
    .sysclk(clk), .reset(rstn_b), .wr_data(wd_b), .wr_en(we_b),
    .wr_ready(rdy_b), .fifo_count(cnt_b), .tx_busy(busy_b), .UART_TX(tx_b));
  uart_tx_fifo #(.BAUD_DIV(10416)) dut_c (
    .sysclk(clk), .reset(rstn_c), .wr_data(wd_c), .wr_en(we_c),
    .wr_ready(rdy_c), .fifo_count(cnt_c), .tx_busy(busy_c), .UART_TX(tx_c));

  // log[n] holds instance A outputs as seen after clock edge n
  localparam int LOGN = 8192;
  logic       tx_log   [LOGN];
  logic       busy_log [LOGN];
  logic       rdy_log  [LOGN];
  logic [2:0] cnt_log  [LOGN];
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      tx_log[cyc]   <= tx_a;
      busy_log[cyc] <= busy_a;
      rdy_log[cyc]  <= rdy_a;
      cnt_log[cyc]  <= cnt_a;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // pat[0] is the start bit, pat[9] the stop bit; every cycle of each bit must match
  task automatic chk_frame(input string name, input int start, input logic [9:0] pat);
    if (start < 0 || start + 160 >= LOGN) begin
      chk({name, " log range"}, start, 0);
      return;
    end
    for (int k = 0; k < 10; k++) begin
      int bad = 0;
      for (int j = 0; j < 16; j++)
        if (tx_log[start + 16*k + j] !== pat[k]) bad++;
      chk($sformatf("%s bit%0d level%0d wrong-cycles", name, k, pat[k]), bad, 0);
    end
  endtask

  function automatic int busy_sum(input int from, input int len);
    int s = 0;
    for (int i = from; i < from + len && i < LOGN; i++) s += int'(busy_log[i]);
    return s;
  endfunction

  task automatic push_a(input logic [7:0] d, output int n);
    @(negedge clk);
    wd_a = d;
    we_a = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    we_a = 1'b0;
  endtask

  task automatic wait_until_a(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    string      name;
    logic [7:0] data;
    logic [9:0] pat;
  } vec_t;
  vec_t vecs[5];

  task automatic run_a;
    int n, n1, lowc;
    vecs[0] = '{"x55", 8'h55, 10'b1_01010101_0};
    vecs[1] = '{"xA3", 8'hA3, 10'b1_10100011_0};
    vecs[2] = '{"x00", 8'h00, 10'b1_00000000_0};
    vecs[3] = '{"xFF", 8'hFF, 10'b1_11111111_0};
    vecs[4] = '{"x80", 8'h80, 10'b1_10000000_0};

    repeat (4) @(posedge clk);
    #1 rstn_a = 1'b1;
    repeat (2) @(negedge clk);
    chk("A reset UART_TX", int'(tx_a), 1);
    chk("A reset tx_busy", int'(busy_a), 0);
    chk("A reset fifo_count", int'(cnt_a), 0);
    chk("A reset wr_ready", int'(rdy_a), 1);

    foreach (vecs[v]) begin
      push_a(vecs[v].data, n);
      wait_until_a(n + 200);
      chk({vecs[v].name, " tx high after write edge"}, int'(tx_log[n]), 1);
      chk({vecs[v].name, " count after write"}, int'(cnt_log[n]), 1);
      chk({vecs[v].name, " tx low two cycles after write"}, int'(tx_log[n+1]), 0);
      chk_frame(vecs[v].name, n + 1, vecs[v].pat);
      chk({vecs[v].name, " busy cycles"}, busy_sum(n, 200), 160);
      chk({vecs[v].name, " busy at last stop cycle"}, int'(busy_log[n+160]), 1);
      chk({vecs[v].name, " idle after frame"}, int'(busy_log[n+161]), 0);
    end

    // burst of six writes; fifth fills the FIFO, sixth is dropped
    @(negedge clk);
    we_a = 1'b1;
    wd_a = 8'h01;
    n1 = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) n1 = cyc;
      wd_a = 8'(i + 1);
    end
    we_a = 1'b0;
    wait_until_a(n1 + 900);
    chk("burst ready before full", int'(rdy_log[n1+3]), 1);
    chk("burst count full", int'(cnt_log[n1+4]), 4);
    chk("burst ready low 6th cycle", int'(rdy_log[n1+4]), 0);
    chk("burst 0x06 dropped", int'(cnt_log[n1+5]), 4);
    for (int f = 0; f < 5; f++)
      chk_frame($sformatf("burst f%0d", f), n1 + 1 + 160*f, {1'b1, 8'(f + 1), 1'b0});
    chk("burst busy cycles", busy_sum(n1, 900), 800);
    chk("burst idle after 5 frames", int'(busy_log[n1+801]), 0);

    // simultaneous write and pop while full
    @(negedge clk);
    we_a = 1'b1;
    wd_a = 8'h11;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) n1 = cyc;
      wd_a = 8'(8'h11 + i);
    end
    we_a = 1'b0;
    wait_until_a(n1 + 160);
    wd_a = 8'h16;
    we_a = 1'b1;
    @(posedge clk);
    #1;
    we_a = 1'b0;
    wait_until_a(n1 + 1100);
    chk("simul count before", int'(cnt_log[n1+160]), 4);
    chk("simul ready before", int'(rdy_log[n1+160]), 0);
    chk("simul count after", int'(cnt_log[n1+161]), 4);
    for (int f = 0; f < 6; f++)
      chk_frame($sformatf("simul f%0d", f), n1 + 1 + 160*f, {1'b1, 8'(8'h11 + f), 1'b0});
    chk("simul busy at end", int'(busy_log[n1+960]), 1);
    chk("simul idle after", int'(busy_log[n1+961]), 0);

    // reset during the third data bit of 0xA3 with two bytes queued
    push_a(8'hA3, n);
    push_a(8'hB1, n1);
    push_a(8'hB2, n1);
    wait_until_a(n + 56);
    rstn_a = 1'b0;
    @(posedge clk);
    #1;
    rstn_a = 1'b1;
    wait_until_a(n + 460);
    chk("rst queued before", int'(cnt_log[n+2]), 2);
    chk("rst data bit2 before", int'(tx_log[n+56]), 0);
    chk("rst UART_TX", int'(tx_log[n+57]), 1);
    chk("rst fifo_count", int'(cnt_log[n+57]), 0);
    chk("rst tx_busy", int'(busy_log[n+57]), 0);
    chk("rst wr_ready", int'(rdy_log[n+57]), 1);
    lowc = 0;
    for (int i = n + 57; i < n + 457; i++) lowc += int'(!tx_log[i]) + int'(busy_log[i]);
    chk("rst no further frames", lowc, 0);
  endtask

  task automatic run_b;
    logic txb [25];
    logic bsb [25];
    int lowc, highc, busyc;
    repeat (4) @(posedge clk);
    #1 rstn_b = 1'b1;
    @(negedge clk);
    wd_b = 8'hFF;
    we_b = 1'b1;
    @(posedge clk);
    #1;
    we_b = 1'b0;
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      txb[j] = tx_b;
      bsb[j] = busy_b;
    end
    lowc = 0; highc = 0; busyc = 0;
    for (int j = 0; j < 25; j++) begin
      lowc  += int'(!txb[j]);
      busyc += int'(bsb[j]);
    end
    for (int j = 3; j <= 20; j++) highc += int'(txb[j]);
    chk("div2 tx high after write", int'(txb[0]), 1);
    chk("div2 start first cycle", int'(txb[1]), 0);
    chk("div2 start second cycle", int'(txb[2]), 0);
    chk("div2 low cycles", lowc, 2);
    chk("div2 high cycles after start", highc, 18);
    chk("div2 frame busy cycles", busyc, 20);
    chk("div2 idle after frame", int'(bsb[21]), 0);
  endtask

  task automatic run_c;
    int lowc;
    logic done;
    repeat (4) @(posedge clk);
    #1 rstn_c = 1'b1;
    @(negedge clk);
    wd_c = 8'h00;
    we_c = 1'b1;
    @(posedge clk);
    #1;
    we_c = 1'b0;
    @(negedge clk);
    chk("full rate tx high after write", int'(tx_c), 1);
    lowc = 0;
    done = 1'b0;
    for (int i = 0; i < 100000; i++) begin
      @(negedge clk);
      if (tx_c) begin
        done = 1'b1;
        break;
      end
      lowc++;
    end
    chk("full rate returned high", int'(done), 1);
    chk("full rate low cycles", lowc, 93744);
    chk("full rate busy in stop", int'(busy_c), 1);
  endtask

  initial begin
    fork
      run_a();
      run_b();
      run_c();
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
